// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: round-robin arbitration of two byte requesters onto one UART transmitter,
// plus a one-entry RX holding register with sticky overrun and TX timeout flags.
module uart_link_ctrl #(
    parameter int BUSY_TIMEOUT = 64,
    parameter int IDLE_GAP     = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       tx_err,
    input  logic       status_clr,
    output logic [7:0] uart_txd,
    output logic       uart_tx_en,
    input  logic       uart_tx_status,
    input  logic [7:0] uart_rxd,
    input  logic       uart_rx_eff,
    output logic       uart_rx_read
);
    typedef enum logic [2:0] {st_idle, st_load, st_wait_busy, st_wait_done, st_gap} state_t;

    // cnt is 1 on the first WAIT_BUSY cycle, so the flag lands BUSY_TIMEOUT cycles after uart_tx_en
    localparam logic [15:0] TIMEOUT_AT = (BUSY_TIMEOUT > 1) ? 16'(BUSY_TIMEOUT - 1) : 16'd1;
    localparam logic [15:0] GAP_LEN    = 16'(IDLE_GAP);
    localparam state_t      AFTER_TX   = (IDLE_GAP == 0) ? st_idle : st_gap;

    state_t      state;
    logic [15:0] cnt;
    logic        rr_last;
    logic        armed;
    logic        can_grant;
    logic        tx_timeout;
    logic        rx_fire;

    always_comb begin
        can_grant  = reset && state == st_idle && uart_tx_status;
        req0_ready = can_grant && req0_valid && (!req1_valid || rr_last);
        req1_ready = can_grant && req1_valid && (!req0_valid || !rr_last);
        tx_timeout = state == st_wait_busy && uart_tx_status && cnt >= TIMEOUT_AT;
        rx_fire    = uart_rx_eff && armed;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state      <= st_idle;
            cnt        <= '0;
            rr_last    <= 1'b1;
            uart_txd   <= '0;
            uart_tx_en <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            uart_tx_en <= req0_ready || req1_ready;
            tx_err     <= tx_timeout || (tx_err && !status_clr);
            case (state)
                st_idle: if (req0_ready || req1_ready) begin
                    uart_txd <= req0_ready ? req0_data : req1_data;
                    rr_last  <= req1_ready;
                    state    <= st_load;
                end
                st_load: begin
                    cnt   <= 16'd1;
                    state <= st_wait_busy;
                end
                st_wait_busy: if (!uart_tx_status) begin
                    state <= st_wait_done;
                end else if (tx_timeout) begin
                    state <= AFTER_TX;
                    cnt   <= 16'd1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                st_wait_done: if (uart_tx_status) begin
                    state <= AFTER_TX;
                    cnt   <= 16'd1;
                end
                st_gap: if (cnt >= GAP_LEN) state <= st_idle; else cnt <= cnt + 16'd1;
                default: state <= st_idle;
            endcase
        end
    end

    // A byte is read once per rx_eff high period; re-arming waits for rx_eff to drop
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            armed        <= 1'b1;
            uart_rx_read <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_overrun   <= 1'b0;
        end else begin
            uart_rx_read <= rx_fire;
            armed        <= !rx_fire && (armed || !uart_rx_eff);
            rx_overrun   <= (rx_fire && rx_valid && !rx_ready) || (rx_overrun && !status_clr);
            if (rx_fire && (!rx_valid || rx_ready)) begin
                rx_data  <= uart_rxd;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
